led_pattern_gen_multi: RTL and testbench

Parametrised test-pattern source for the HUB75-style LED panel driver. It produces one dual-half row (top and bottom half-panel) per valid/ready transfer, walking row addresses 0..NUM_ROW_ADDR-1 per frame. Mode and colour are sampled only at frame boundaries, and an animated scroll advances per frame count. It sits between the mode-select register and the row shifter/PWM stage.

---
 rtl/led_pattern_gen_multi.sv | 180 ++++++++++++++++++
 tb/tb_led_pattern_gen_multi.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen_multi.sv
// Test-pattern source for a HUB75-style panel: one dual-half row per
// valid/ready transfer, with mode/colour and scroll updated per frame.
//
// Ports:
//   clk_in, reset_in    clock, synchronous active-high reset
//   enable_in           run request (IDLE and frame boundaries)
//   mode_in, color_in   pattern select and colour, latched at frame start
//   row_out             {top_r,top_g,top_b,bot_r,bot_g,bot_b}
//   row_valid_out       row_out/row_address_out valid
//   row_ready_in        downstream accept
//   row_address_out     address of presented row
//   frame_done_out      pulse after last row of a frame is accepted
module led_pattern_gen_multi #(
  parameter int NUM_COLS     = 64,
  parameter int NUM_ROW_ADDR = 16,
  parameter int BAR_WIDTH    = 8,
  parameter int SCROLL_DIV   = 4,
  localparam int ADDR_W      = $clog2(NUM_ROW_ADDR)
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  enable_in,
  input  logic [3:0]            mode_in,
  input  logic [2:0]            color_in,
  output logic [6*NUM_COLS-1:0] row_out,
  output logic                  row_valid_out,
  input  logic                  row_ready_in,
  output logic [ADDR_W-1:0]     row_address_out,
  output logic                  frame_done_out
);

  localparam int SW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int N  = NUM_COLS;

  typedef enum logic [1:0] {IDLE, GEN, VALID} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [6*N-1:0]    row_q, row_nxt, row_gen;
  logic              valid, valid_nxt;
  logic              done, done_nxt;
  logic [3:0]        mode_q, mode_nxt;
  logic [2:0]        color_q, color_nxt;
  logic [SW-1:0]     pos, pos_nxt;
  logic [DW-1:0]     div, div_nxt;
  logic              latch;
  logic [2:0]        t, b;

  function automatic logic [2:0] pix(
    input logic [3:0]    m,
    input logic [2:0]    k,
    input int            c,
    input int            y,
    input logic [SW-1:0] p
  );
    logic [2:0] code;
    code = 3'b000;
    if (!m[3]) begin
      code = m[2:0];
    end else begin
      unique case (m[2:0])
        3'd0:    code = (((c ^ y) & 1) == 0) ? k : 3'b000;
        3'd1:    code = 3'((c / BAR_WIDTH) % 8);
        3'd2:    code = 3'(y % 8);
        3'd3:    code = (c == int'(p)) ? k : 3'b000;
        default: code = 3'b000;
      endcase
    end
    return code;
  endfunction

  // Pixel code bit 0/1/2 drives the red/green/blue plane of each half.
  always_comb begin
    row_gen = '0;
    t = 3'b000;
    b = 3'b000;
    for (int c = 0; c < N; c++) begin
      t = pix(mode_q, color_q, c, int'(addr), pos);
      b = pix(mode_q, color_q, c, int'(addr) + NUM_ROW_ADDR, pos);
      row_gen[5*N+c] = t[0];
      row_gen[4*N+c] = t[1];
      row_gen[3*N+c] = t[2];
      row_gen[2*N+c] = b[0];
      row_gen[N+c]   = b[1];
      row_gen[c]     = b[2];
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    row_nxt   = row_q;
    valid_nxt = valid;
    done_nxt  = 1'b0;
    mode_nxt  = mode_q;
    color_nxt = color_q;
    pos_nxt   = pos;
    div_nxt   = div;
    latch     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable_in) begin
          latch     = 1'b1;
          addr_nxt  = '0;
          state_nxt = GEN;
        end
      end
      GEN: begin
        row_nxt   = row_gen;
        valid_nxt = 1'b1;
        state_nxt = VALID;
      end
      VALID: begin
        if (row_ready_in) begin
          valid_nxt = 1'b0;
          if (addr != ADDR_W'(NUM_ROW_ADDR - 1)) begin
            addr_nxt  = addr + ADDR_W'(1);
            state_nxt = GEN;
          end else begin
            done_nxt = 1'b1;
            addr_nxt = '0;
            if (div == DW'(SCROLL_DIV - 1)) begin
              div_nxt = '0;
              pos_nxt = (pos == SW'(NUM_COLS - 1)) ? '0 : pos + SW'(1);
            end else begin
              div_nxt = div + DW'(1);
            end
            if (enable_in) begin
              latch     = 1'b1;
              state_nxt = GEN;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A new pattern restarts the scroll from column 0.
    if (latch) begin
      mode_nxt  = mode_in;
      color_nxt = color_in;
      if (mode_in != mode_q) begin
        pos_nxt = '0;
        div_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state   <= IDLE;
      addr    <= '0;
      row_q   <= '0;
      valid   <= 1'b0;
      done    <= 1'b0;
      mode_q  <= '0;
      color_q <= '0;
      pos     <= '0;
      div     <= '0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      row_q   <= row_nxt;
      valid   <= valid_nxt;
      done    <= done_nxt;
      mode_q  <= mode_nxt;
      color_q <= color_nxt;
      pos     <= pos_nxt;
      div     <= div_nxt;
    end
  end

  assign row_out         = row_q;
  assign row_valid_out   = valid;
  assign row_address_out = addr;
  assign frame_done_out  = done;

endmodule

// File: tb/tb_led_pattern_gen_multi.sv
// Directed bench for led_pattern_gen_multi on an 8-column, 4-address
// panel: solid, bars, checker, backpressure, scroll wrap, reset, stop.
module tb_led_pattern_gen_multi;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        enable_in;
  logic [3:0]  mode_in;
  logic [2:0]  color_in;
  logic [47:0] row_out;
  logic        row_valid_out;
  logic        row_ready_in;
  logic [1:0]  row_address_out;
  logic        frame_done_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [47:0] ROW1  = 48'hFF0000_FF0000;
  localparam logic [47:0] ROW9  = 48'hCCF000_CCF000;
  localparam logic [47:0] ROW8E = 48'h000055_000055;
  localparam logic [47:0] ROW8O = 48'h0000AA_0000AA;
  localparam logic [47:0] ROW2  = 48'h00FF00_00FF00;

  led_pattern_gen_multi #(
    .NUM_COLS(8),
    .NUM_ROW_ADDR(4),
    .BAR_WIDTH(2),
    .SCROLL_DIV(2)
  ) dut (
    .clk_in(clk),
    .reset_in(reset_in),
    .enable_in(enable_in),
    .mode_in(mode_in),
    .color_in(color_in),
    .row_out(row_out),
    .row_valid_out(row_valid_out),
    .row_ready_in(row_ready_in),
    .row_address_out(row_address_out),
    .frame_done_out(frame_done_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] got,
                     input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get_row(input string tag, input logic [1:0] ea,
                         input logic [47:0] er, input bit take,
                         output int waited);
    waited = 0;
    while (!row_valid_out && waited < 10) begin
      step();
      waited++;
    end
    chk({tag, "_v"}, 48'(row_valid_out), 48'd1);
    chk({tag, "_a"}, 48'(row_address_out), 48'(ea));
    chk({tag, "_r"}, row_out, er);
    if (take) begin
      row_ready_in = 1'b1;
      step();
    end
  endtask

  task automatic frame_same(input string tag, input logic [47:0] er,
                            input logic [3:0] nm, input logic [2:0] nc);
    int w;
    for (int a = 0; a < 4; a++) begin
      get_row($sformatf("%s_a%0d", tag, a), 2'(a), er, 1'b1, w);
      if (a == 0) begin
        mode_in  = nm;
        color_in = nc;
      end
    end
    chk({tag, "_done"}, 48'(frame_done_out), 48'd1);
  endtask

  initial begin
    int w;
    int hits;
    logic [7:0] sb;
    reset_in     = 1'b1;
    enable_in    = 1'b0;
    mode_in      = 4'd0;
    color_in     = 3'd0;
    row_ready_in = 1'b1;
    repeat (3) step();
    reset_in = 1'b0;
    step();
    chk("rst_row", row_out, 48'd0);
    chk("rst_v", 48'(row_valid_out), 48'd0);
    chk("rst_a", 48'(row_address_out), 48'd0);
    chk("rst_d", 48'(frame_done_out), 48'd0);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (row_valid_out) hits++;
    end
    chk("idle_novalid", 48'(hits), 48'd0);

    enable_in = 1'b1;
    mode_in   = 4'd1;
    step();
    chk("lat1", 48'(row_valid_out), 48'd0);
    step();
    chk("lat2", 48'(row_valid_out), 48'd1);
    get_row("m1a0", 2'd0, ROW1, 1'b1, w);
    chk("m1_drop", 48'(row_valid_out), 48'd0);
    get_row("m1a1", 2'd1, ROW1, 1'b1, w);
    chk("m1_gap", 48'(w), 48'd1);
    get_row("m1a2", 2'd2, ROW1, 1'b1, w);
    chk("m1_nodone", 48'(frame_done_out), 48'd0);
    mode_in = 4'd9;
    get_row("m1a3", 2'd3, ROW1, 1'b1, w);
    chk("m1_done1", 48'(frame_done_out), 48'd1);
    step();
    chk("m1_done0", 48'(frame_done_out), 48'd0);

    frame_same("m9", ROW9, 4'd8, 3'b100);

    get_row("m8a0", 2'd0, ROW8E, 1'b0, w);
    row_ready_in = 1'b0;
    mode_in      = 4'd2;
    repeat (5) step();
    chk("bp_v", 48'(row_valid_out), 48'd1);
    chk("bp_a", 48'(row_address_out), 48'd0);
    chk("bp_r", row_out, ROW8E);
    row_ready_in = 1'b1;
    step();
    get_row("m8a1", 2'd1, ROW8O, 1'b1, w);
    get_row("m8a2", 2'd2, ROW8E, 1'b1, w);
    get_row("m8a3", 2'd3, ROW8O, 1'b1, w);
    chk("m8_done", 48'(frame_done_out), 48'd1);

    frame_same("m2", ROW2, 4'd11, 3'b001);

    for (int f = 0; f < 18; f++) begin
      sb = 8'd1 << ((f / 2) % 8);
      frame_same($sformatf("sc%0d", f), {sb, 16'h0, sb, 16'h0},
                 4'd11, 3'b001);
    end

    get_row("rm0", 2'd0, 48'h020000_020000, 1'b1, w);
    get_row("rm1", 2'd1, 48'h020000_020000, 1'b1, w);
    get_row("rm2", 2'd2, 48'h020000_020000, 1'b0, w);
    reset_in = 1'b1;
    step();
    chk("mrst_v", 48'(row_valid_out), 48'd0);
    chk("mrst_a", 48'(row_address_out), 48'd0);
    chk("mrst_r", row_out, 48'd0);
    reset_in = 1'b0;
    get_row("pr0", 2'd0, 48'h010000_010000, 1'b1, w);
    chk("pr_lat", 48'(w), 48'd2);
    enable_in = 1'b0;
    get_row("pr1", 2'd1, 48'h010000_010000, 1'b1, w);
    get_row("pr2", 2'd2, 48'h010000_010000, 1'b1, w);
    get_row("pr3", 2'd3, 48'h010000_010000, 1'b1, w);
    chk("stop_done", 48'(frame_done_out), 48'd1);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (row_valid_out) hits++;
    end
    chk("stop_idle", 48'(hits), 48'd0);
    chk("stop_d0", 48'(frame_done_out), 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
